id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register of the segmented RV32I core. It captures decoded operands, immediate, destination and control bits from the decode stage and presents them to execute. Its `ex_entrada`/`ex_alu_op` outputs drive the ALU control decoder directly. The block also contains load-use hazard detection and bubble insertion, branch-flush handling with a pending-flush latch under memory hold, and saturating stall/flush counters.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `CNT_W`, 16, width of performance counters

Ports:
- `clk`  in  1  core clock
- `reset_n`  in  1  reset; asynchronous assert, active-low
- `id_valid`  in  1  decode holds a real instruction
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN  decoded operands
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register addresses
- `id_uses_rs1`, `id_uses_rs2`  in  1  operand actually read by the instruction
- `id_entrada`  in  4  `{instr[30], funct3}`
- `id_alu_op`  in  3  format class: R=000, I=001, B=010, S=011, U=100, J=101, L=110
- `id_ctrl`  in  7  packed `{reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, jump}`
- `ex_flush`  in  1  branch/jump resolved taken in EX
- `mem_hold`  in  1  MEM stage stalled; freeze EX
- `id_stall`  out  1  hold PC and IF/ID this cycle
- `ex_valid`  out  1  EX holds a real instruction
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN  registered copies
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  registered copies
- `ex_entrada`  out  4  to ALU control `entrada`
- `ex_alu_op`  out  3  to ALU control `alu_op`
- `ex_ctrl`  out  7  registered control bits
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating event counters

## Operation
- **Load-use hazard.** `hazard = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`. This is combinational from the registered EX state.
- **Stall output.** `id_stall = hazard | mem_hold`.
- **Bubble.** `ex_valid = 0`, `ex_ctrl = 0`, `ex_alu_op = 000`, `ex_entrada = 0`, and all data/address fields set to 0.
- **Per-edge action, priority highest first:**
  1. `mem_hold`: EX register keeps its value. If `ex_flush` is also high, set `flush_pending`.
  2. `ex_flush | flush_pending`: load a bubble and clear `flush_pending`.
  3. `hazard`: load a bubble. ID is held by `id_stall`.
  4. Otherwise: load all `id_*` fields. `ex_valid = id_valid`. If `id_valid = 0`, control fields load as 0.
- **FSM (2 states).**
  - `RUN`: normal operation.
  - `FLUSH_PEND`: entered when `mem_hold & ex_flush`. Exited to `RUN` on the first edge with `mem_hold = 0`, when the bubble loads.
  - `flush_pending` is 1 only in `FLUSH_PEND`.
- **Counters.**
  - `stall_cnt` increments on each edge where action 3 is taken.
  - `flush_cnt` increments on each edge where action 2 is taken.
  - Both saturate at all-ones and never wrap.
  - Neither counter increments while `mem_hold` is high.
- **Pass-through fields.** `id_entrada` bit 3 passes unmodified for every format. Masking bit 3 for I/B/S/L formats is ALU control's job, not this block's.

## Timing
- One-cycle latency: ID values at edge N appear on `ex_*` after edge N.
- `id_stall` is combinational. It must settle within the same cycle, before the IF/ID enable.
- A load-use stall lasts exactly one cycle. Once the bubble enters EX, `hazard` is 0 unless `mem_hold` is high.
- **Reset (`reset_n` low, asynchronous):**
  - All `ex_*` outputs become 0, giving a bubble.
  - Counters become 0, FSM goes to `RUN`, `flush_pending = 0`.
  - Reset asserted mid-stall or mid-hold discards all pending state.
  - Release is synchronous to `clk`; the first capture happens on the first edge after release.
- **Flush vs. hazard in the same cycle:** the flush wins and only `flush_cnt` increments.
- **Hold released:** the pending flush is applied on the first non-hold edge, even if `ex_flush` is low then.

## Structure
- Shared package `pipe_pkg`:
  - `alu_op_t` enum (`ALUOP_R` … `ALUOP_L`, codes above)
  - `ex_ctrl_t` packed struct in the bit order given above
  - `BUBBLE_CTRL` constant = 0
- One sub-module, `hazard_unit`: purely combinational load-use compare that outputs `hazard`.
- The register, FSM and counters live in `id_ex_stage`.

## Test plan
- **Reset:** assert `reset_n = 0` mid-run → all `ex_*` = 0, counters = 0. First edge after release captures `id_pc = 0x100`.
- **Load-use:** EX holds LW with `rd = 5`; ID presents ADD reading `rs2 = 5` → `id_stall = 1` for one cycle, bubble enters EX, ADD reaches EX next cycle, `stall_cnt = 1`.
- **Zero register:** EX holds LW with `rd = 0`; ID reads `rs1 = 0` → no stall, `stall_cnt` unchanged.
- **Flush during hold:** `ex_flush = 1` with `mem_hold = 1` for 3 cycles → EX is frozen for those 3 cycles, then a bubble loads on the release edge. `flush_cnt = 1`.
- **Flush vs. hazard:** both in the same cycle → bubble loads, `flush_cnt` increments, `stall_cnt` unchanged.
- **Saturation and pass-through:** preload `stall_cnt = 0xFFFF` → it stays `0xFFFF` after a further stall. SRAI with `id_entrada = 4'b1101`, `id_alu_op = 001` → `ex_entrada = 1101`, `ex_alu_op = 001`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline: ALU format class, EX control bundle, ID/EX FSM states.
package pipe_pkg;

    typedef enum logic [2:0] {
        ALUOP_R = 3'b000,
        ALUOP_I = 3'b001,
        ALUOP_B = 3'b010,
        ALUOP_S = 3'b011,
        ALUOP_U = 3'b100,
        ALUOP_J = 3'b101,
        ALUOP_L = 3'b110
    } alu_op_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic jump;
    } ex_ctrl_t;

    localparam ex_ctrl_t BUBBLE_CTRL = '0;

    typedef enum logic {
        ST_RUN        = 1'b0,
        ST_FLUSH_PEND = 1'b1
    } idex_state_t;

endpackage

// File: rtl/hazard_unit.sv
// Load-use detector: the instruction in ID reads a register that a load in EX has not yet produced.
module hazard_unit (
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    output logic       o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 is never written, so a load targeting it cannot create a dependency
    assign o_hazard  = i_id_valid && i_ex_valid && i_ex_mem_read && (i_ex_rd != 5'd0)
                       && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling that survives
// a MEM hold, and saturating stall/flush event counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [3:0]       id_entrada,
    input  logic [2:0]       id_alu_op,
    input  logic [6:0]       id_ctrl,
    input  logic             ex_flush,
    input  logic             mem_hold,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_entrada,
    output logic [2:0]       ex_alu_op,
    output logic [6:0]       ex_ctrl,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [3:0]      r_entrada;
    alu_op_t         r_alu_op;
    ex_ctrl_t        r_ctrl;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    idex_state_t     r_state;

    idex_state_t     w_state_nxt;
    logic            w_hazard;
    logic            w_flush_pending;
    logic            w_bubble;
    logic            w_load_id;
    logic            w_cnt_stall;
    logic            w_cnt_flush;

    hazard_unit u_hazard (
        .i_id_valid    (id_valid),
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rd       (r_rd),
        .o_hazard      (w_hazard)
    );

    assign w_flush_pending = (r_state == ST_FLUSH_PEND);
    assign id_stall        = w_hazard || mem_hold;

    always_comb begin
        w_state_nxt = r_state;
        w_bubble    = 1'b0;
        w_load_id   = 1'b0;
        w_cnt_stall = 1'b0;
        w_cnt_flush = 1'b0;
        if (mem_hold) begin
            // EX frozen; remember a taken branch so it is not lost behind the hold
            if (ex_flush) w_state_nxt = ST_FLUSH_PEND;
        end else if (ex_flush || w_flush_pending) begin
            w_bubble    = 1'b1;
            w_cnt_flush = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (w_hazard) begin
            w_bubble    = 1'b1;
            w_cnt_stall = 1'b1;
        end else begin
            w_load_id   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_entrada   <= '0;
            r_alu_op    <= ALUOP_R;
            r_ctrl      <= BUBBLE_CTRL;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_pc       <= '0;
                r_rs1_data <= '0;
                r_rs2_data <= '0;
                r_imm      <= '0;
                r_rs1      <= '0;
                r_rs2      <= '0;
                r_rd       <= '0;
                r_entrada  <= '0;
                r_alu_op   <= ALUOP_R;
                r_ctrl     <= BUBBLE_CTRL;
            end else if (w_load_id) begin
                r_valid    <= id_valid;
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_entrada  <= id_entrada;
                r_alu_op   <= alu_op_t'(id_alu_op);
                r_ctrl     <= id_valid ? ex_ctrl_t'(id_ctrl) : BUBBLE_CTRL;
            end
            if (w_cnt_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_cnt_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_entrada  = r_entrada;
    assign ex_alu_op   = r_alu_op;
    assign ex_ctrl     = r_ctrl;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage against a behavioural model of the EX register.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;   // narrow counters so saturation is reachable quickly
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic            id_uses_rs1, id_uses_rs2;
    logic [3:0]      id_entrada;
    logic [2:0]      id_alu_op;
    logic [6:0]      id_ctrl;
    logic            ex_flush, mem_hold;
    logic            id_stall, ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [3:0]      ex_entrada;
    logic [2:0]      ex_alu_op;
    logic [6:0]      ex_ctrl;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_entrada(id_entrada), .id_alu_op(id_alu_op), .id_ctrl(id_ctrl),
        .ex_flush(ex_flush), .mem_hold(mem_hold), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_entrada(ex_entrada),
        .ex_alu_op(ex_alu_op), .ex_ctrl(ex_ctrl),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, rs1d, rs2d, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      ent;
        logic [2:0]      op;
        logic [6:0]      ctrl;
    } ex_t;

    ex_t m;            // expected EX contents
    int  m_stall, m_flush;
    bit  m_pend;       // a flush seen during hold not yet applied
    int  n_cmp = 0, n_err = 0;

    localparam logic [6:0] C_LW  = 7'b1101100;
    localparam logic [6:0] C_ADD = 7'b1000000;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic ex_t dut_ex();
        return '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                 ex_rs1, ex_rs2, ex_rd, ex_entrada, ex_alu_op, ex_ctrl};
    endfunction

    function automatic bit model_hazard();
        // ID needs a register that the load now in EX will only deliver from MEM
        return id_valid && m.valid && m.ctrl[5] && (m.rd != 0) &&
               ((id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd));
    endfunction

    task automatic model_reset();
        m = '0; m_stall = 0; m_flush = 0; m_pend = 0;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                         input bit u1, u2, input logic [3:0] ent, input logic [2:0] op,
                         input logic [6:0] ctrl, input bit fl, hold);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_entrada = ent; id_alu_op = op;
        id_ctrl = ctrl; ex_flush = fl; mem_hold = hold;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    endtask

    // one clock: check stall, advance model, check registered state; ends at negedge
    task automatic cycle(input string tag);
        bit hz;
        #1;
        hz = model_hazard();
        chk({tag, ".stall"}, id_stall, hz | mem_hold);
        @(posedge clk);
        if (mem_hold) begin
            if (ex_flush) m_pend = 1;
        end else if (ex_flush || m_pend) begin
            m = '0; m_pend = 0; m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        end else if (hz) begin
            m = '0; m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        end else begin
            m = '{id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
                  id_rd, id_entrada, id_alu_op, id_valid ? id_ctrl : 7'd0};
        end
        #1;
        chk({tag, ".ex"}, dut_ex(), m);
        chk({tag, ".scnt"}, stall_cnt, m_stall);
        chk({tag, ".fcnt"}, flush_cnt, m_flush);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // load-use on rs2
        drive(1, 32'h10, 1, 2, 5, 1, 0, 4'b0010, 3'b110, C_LW, 0, 0); cycle("lu_lw");
        drive(1, 32'h14, 3, 5, 6, 1, 1, 4'b0000, 3'b000, C_ADD, 0, 0);
        #1 chk("lu_stall_hi", id_stall, 1'b1);
        cycle("lu_bub");
        chk("lu_bubble", ex_valid, 1'b0);
        cycle("lu_add");
        chk("lu_add_pc", ex_pc, 32'h14);
        chk("lu_cnt", stall_cnt, 1);

        // load to x0 never stalls
        drive(1, 32'h20, 1, 2, 0, 1, 0, 4'b0010, 3'b110, C_LW, 0, 0); cycle("z_lw");
        drive(1, 32'h24, 0, 0, 7, 1, 1, 4'b0000, 3'b000, C_ADD, 0, 0); cycle("z_add");
        chk("z_cnt", stall_cnt, 1);

        // flush under a 3-cycle hold, applied on the release edge
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30 + i, 1, 2, 3, 1, 1, 4'h0, 3'b000, C_ADD, 1, 1);
            cycle("fh_hold");
            chk("fh_frozen", ex_pc, 32'h24);
        end
        drive(1, 32'h40, 1, 2, 3, 1, 1, 4'h0, 3'b000, C_ADD, 0, 0); cycle("fh_rel");
        chk("fh_cnt", flush_cnt, 1);
        chk("fh_bub", ex_valid, 1'b0);

        // flush and hazard together: flush wins
        drive(1, 32'h50, 1, 2, 9, 1, 0, 4'b0010, 3'b110, C_LW, 0, 0); cycle("fz_lw");
        drive(1, 32'h54, 9, 0, 4, 1, 0, 4'h0, 3'b000, C_ADD, 1, 0); cycle("fz_both");
        chk("fz_scnt", stall_cnt, 1);
        chk("fz_fcnt", flush_cnt, 2);

        // SRAI pass-through of entrada bit 3
        drive(1, 32'h60, 1, 0, 2, 1, 0, 4'b1101, 3'b001, 7'b1000100, 0, 0); cycle("srai");
        chk("srai_ent", ex_entrada, 4'b1101);
        chk("srai_op", ex_alu_op, 3'b001);

        // drive stall counter into saturation
        for (int i = 0; i < CMAX + 3; i++) begin
            drive(1, 32'h100 + 8 * i, 1, 2, 5, 1, 0, 4'h2, 3'b110, C_LW, 0, 0); cycle("sat_lw");
            drive(1, 32'h104 + 8 * i, 5, 0, 6, 1, 0, 4'h0, 3'b000, C_ADD, 0, 0); cycle("sat_st");
        end
        chk("sat_cnt", stall_cnt, CMAX);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 4'($urandom), 3'($urandom_range(0, 6)), 7'($urandom),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3);
            cycle("rnd");
        end

        // reset mid-hold with a pending flush discards everything
        drive(1, 32'h70, 1, 2, 3, 1, 1, 4'h0, 3'b000, C_ADD, 1, 1); cycle("rst_pre");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_ex", dut_ex(), m);
        chk("rst_cnt", {stall_cnt, flush_cnt}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 32'h100, 1, 2, 3, 1, 1, 4'h0, 3'b000, C_ADD, 0, 0); cycle("rst_rel");
        chk("rst_pc", ex_pc, 32'h100);
        chk("rst_fcnt", flush_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
